// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with load clamping, terminal count and terminal pulse.
// All arithmetic is per 4-bit digit; every digit updates on the same clock edge.
module bcd_counter_n #(
    parameter int DIGITS        = 2,
    parameter bit WRAP          = 1'b1,
    parameter bit STEP_TC_PULSE = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  loadN,
    input  logic                  enable1,
    input  logic                  enable2,
    input  logic                  up,
    input  logic [4*DIGITS-1:0]   datain,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  tc_pulse,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        if (d > 4'd9) begin
            return 4'd9;
        end else begin
            return d;
        end
    endfunction

    function automatic logic [3:0] dec_digit(input logic [3:0] d);
        if (d == 4'd0) begin
            return 4'd9;
        end else begin
            return d - 4'd1;
        end
    endfunction

    function automatic logic [3:0] inc_digit(input logic [3:0] d);
        if (d >= 4'd9) begin
            return 4'd0;
        end else begin
            return d + 4'd1;
        end
    endfunction

    function automatic logic all_digits_eq(input logic [W-1:0] v, input logic [3:0] x);
        logic eq;
        eq = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] != x) begin
                eq = 1'b0;
            end else begin
                eq = eq;
            end
        end
        return eq;
    endfunction

    function automatic logic is_terminal(input logic [W-1:0] v, input logic dir_up);
        if (dir_up) begin
            return all_digits_eq(v, 4'd9);
        end else begin
            return all_digits_eq(v, 4'd0);
        end
    endfunction

    logic [W-1:0] count_r;
    logic         tc_pulse_r;
    logic         load_err_r;

    logic [W-1:0] step_val_s;
    logic [W-1:0] load_val_s;
    logic         load_bad_s;
    logic         at_term_s;
    logic         step_en_s;
    logic         step_block_s;
    logic [W-1:0] count_nxt_s;
    logic         pulse_nxt_s;
    logic         err_nxt_s;

    assign at_term_s    = is_terminal(count_r, up);
    assign step_en_s    = enable1 & enable2;
    // A saturating counter parked on its terminal value takes no step at all.
    assign step_block_s = (WRAP == 1'b0) & at_term_s;

    // Ripple-free digit chain: digit k steps when every lower digit is at its rollover value.
    always_comb begin
        logic       carry_v;
        logic [3:0] d_v;
        step_val_s = count_r;
        carry_v    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            d_v = count_r[4*k +: 4];
            if (carry_v) begin
                step_val_s[4*k +: 4] = up ? inc_digit(d_v) : dec_digit(d_v);
            end else begin
                step_val_s[4*k +: 4] = d_v;
            end
            carry_v = carry_v & (up ? (d_v == 4'd9) : (d_v == 4'd0));
        end
    end

    // Load value with invalid nibbles clamped to 9, flagging any clamp.
    always_comb begin
        load_val_s = '0;
        load_bad_s = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            load_val_s[4*k +: 4] = clamp_digit(datain[4*k +: 4]);
            if (datain[4*k +: 4] > 4'd9) begin
                load_bad_s = 1'b1;
            end else begin
                load_bad_s = load_bad_s;
            end
        end
    end

    // Next-state selection: load, then step, then hold.
    always_comb begin
        count_nxt_s = count_r;
        pulse_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        if (!loadN) begin
            count_nxt_s = load_val_s;
            err_nxt_s   = load_bad_s;
        end else if (step_en_s && !step_block_s) begin
            count_nxt_s = step_val_s;
            pulse_nxt_s = STEP_TC_PULSE & is_terminal(step_val_s, up);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_r    <= '0;
            tc_pulse_r <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            tc_pulse_r <= pulse_nxt_s;
            load_err_r <= err_nxt_s;
        end
    end

    assign count    = count_r;
    assign tc       = at_term_s;
    assign tc_pulse = tc_pulse_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Randomised and directed bench for bcd_counter_n, three configurations in lockstep
// against a decimal-integer reference model.
module tb_bcd_counter_n;

    logic        clk;
    logic        resetN;
    logic        loadN;
    logic        enable1;
    logic        enable2;
    logic        up;
    logic [31:0] din;

    logic [7:0]  cnt_a, cnt_b;
    logic [11:0] cnt_c;
    logic        tc_a, tc_b, tc_c;
    logic        tp_a, tp_b, tp_c;
    logic        le_a, le_b, le_c;

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b1), .STEP_TC_PULSE(1'b1)) dut_a (
        .clk(clk), .resetN(resetN), .loadN(loadN), .enable1(enable1), .enable2(enable2),
        .up(up), .datain(din[7:0]), .count(cnt_a), .tc(tc_a), .tc_pulse(tp_a), .load_err(le_a));

    bcd_counter_n #(.DIGITS(2), .WRAP(1'b0), .STEP_TC_PULSE(1'b1)) dut_b (
        .clk(clk), .resetN(resetN), .loadN(loadN), .enable1(enable1), .enable2(enable2),
        .up(up), .datain(din[7:0]), .count(cnt_b), .tc(tc_b), .tc_pulse(tp_b), .load_err(le_b));

    bcd_counter_n #(.DIGITS(3), .WRAP(1'b1), .STEP_TC_PULSE(1'b1)) dut_c (
        .clk(clk), .resetN(resetN), .loadN(loadN), .enable1(enable1), .enable2(enable2),
        .up(up), .datain(din[11:0]), .count(cnt_c), .tc(tc_c), .tc_pulse(tp_c), .load_err(le_c));

    logic [31:0] obs_cnt [3];
    logic        obs_tc  [3];
    logic        obs_tp  [3];
    logic        obs_le  [3];

    assign obs_cnt[0] = {24'd0, cnt_a};
    assign obs_cnt[1] = {24'd0, cnt_b};
    assign obs_cnt[2] = {20'd0, cnt_c};
    assign obs_tc[0] = tc_a;  assign obs_tc[1] = tc_b;  assign obs_tc[2] = tc_c;
    assign obs_tp[0] = tp_a;  assign obs_tp[1] = tp_b;  assign obs_tp[2] = tp_c;
    assign obs_le[0] = le_a;  assign obs_le[1] = le_b;  assign obs_le[2] = le_c;

    localparam int DG [3] = '{2, 2, 3};
    localparam int WR [3] = '{1, 0, 1};

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain decimal integers.
    int mv [3];
    bit mp [3];
    bit me [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r;
        int t;
        r = 32'd0;
        t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 0;
            mp[i] = 1'b0;
            me[i] = 1'b0;
        end
    endtask

    // Reference behaviour for one rising edge, using the inputs held across it.
    task automatic model_edge();
        int mx, term, v, nib;
        bit bad;
        for (int i = 0; i < 3; i++) begin
            mx = pow10(DG[i]) - 1;
            mp[i] = 1'b0;
            me[i] = 1'b0;
            if (!loadN) begin
                v = 0;
                bad = 1'b0;
                for (int k = 0; k < DG[i]; k++) begin
                    nib = int'((din >> (4*k)) & 32'hF);
                    if (nib > 9) begin
                        bad = 1'b1;
                        nib = 9;
                    end
                    v = v + nib * pow10(k);
                end
                mv[i] = v;
                me[i] = bad;
            end else if (enable1 && enable2) begin
                term = up ? mx : 0;
                if (mv[i] == term) begin
                    if (WR[i] != 0) mv[i] = up ? 0 : mx;
                end else begin
                    mv[i] = up ? mv[i] + 1 : mv[i] - 1;
                    mp[i] = (mv[i] == term);
                end
            end
        end
    endtask

    task automatic chk_all(input string tag);
        int mx;
        bit exp_tc;
        for (int i = 0; i < 3; i++) begin
            mx = pow10(DG[i]) - 1;
            exp_tc = up ? (mv[i] == mx) : (mv[i] == 0);
            chk($sformatf("%s_%0d_count", tag, i), obs_cnt[i], to_bcd(mv[i], DG[i]));
            chk($sformatf("%s_%0d_tc", tag, i), {31'd0, obs_tc[i]}, {31'd0, exp_tc});
            chk($sformatf("%s_%0d_tc_pulse", tag, i), {31'd0, obs_tp[i]}, {31'd0, mp[i]});
            chk($sformatf("%s_%0d_load_err", tag, i), {31'd0, obs_le[i]}, {31'd0, me[i]});
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic do_load(input logic [31:0] v, input string tag);
        loadN = 1'b0;
        din = v;
        tick(tag);
        loadN = 1'b1;
    endtask

    task automatic do_steps(input int n, input logic dir, input string tag);
        up = dir;
        enable1 = 1'b1;
        enable2 = 1'b1;
        for (int i = 0; i < n; i++) tick(tag);
        enable1 = 1'b0;
        enable2 = 1'b0;
    endtask

    initial begin
        resetN  = 1'b0;
        loadN   = 1'b1;
        enable1 = 1'b0;
        enable2 = 1'b0;
        up      = 1'b0;
        din     = 32'd0;
        model_reset();
        #3;
        chk_all("reset_dn");
        up = 1'b1;
        #1;
        chk_all("reset_up");
        up = 1'b0;
        #8 resetN = 1'b1;

        // Down count across a borrow, then wrap from zero.
        do_load(32'h10, "ld10");
        do_steps(2, 1'b0, "dn_borrow");
        do_load(32'h00, "ld00");
        do_steps(1, 1'b0, "dn_wrap");

        // Saturating down to zero, then stuck with no re-pulse.
        do_load(32'h01, "ld01");
        do_steps(6, 1'b0, "dn_sat");

        // Up count carries and wrap/terminal pulse on the wider counter.
        do_load(32'h199, "ld199");
        do_steps(1, 1'b1, "up_carry");
        do_load(32'h999, "ld999");
        do_steps(1, 1'b1, "up_wrap");
        do_load(32'h998, "ld998");
        do_steps(2, 1'b1, "up_term");

        // Invalid digits are clamped and flagged.
        do_load(32'hA5, "ld_a5");
        do_load(32'h3F, "ld_3f");
        do_load(32'h42, "ld_42");
        tick("err_clear");

        // Only one enable: no counting.
        enable1 = 1'b1;
        enable2 = 1'b0;
        for (int i = 0; i < 10; i++) tick("half_en");

        // Load wins over a simultaneous step.
        enable2 = 1'b1;
        do_load(32'h57, "ld_prio");
        enable1 = 1'b0;
        enable2 = 1'b0;

        // Asynchronous reset while counting.
        do_load(32'h37, "ld37");
        enable1 = 1'b1;
        enable2 = 1'b1;
        up = 1'b0;
        #3;
        resetN = 1'b0;
        #1;
        model_reset();
        chk_all("async_rst");
        up = 1'b1;
        #1;
        chk_all("rst_dir_up");
        up = 1'b0;
        #1;
        chk_all("rst_dir_dn");
        #1 resetN = 1'b1;
        tick("rst_recover");
        enable1 = 1'b0;
        enable2 = 1'b0;

        // Randomised traffic, biased toward the range ends.
        for (int n = 0; n < 400; n++) begin
            loadN   = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            enable1 = ($urandom_range(0, 3) != 0);
            enable2 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            case ($urandom_range(0, 3))
                0:       din = 32'h0;
                1:       din = 32'h999;
                2:       din = 32'h001;
                default: din = $urandom;
            endcase
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
